// File: rtl/mem_access_sequencer_pkg.sv
// Shared processor package: execute-stage command encodings plus the
// memory access sequencer's state, op-type and request payload types.
package mem_access_sequencer_pkg;

  localparam int unsigned CNT_W       = 4;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned HALF_W      = 16;
  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned WORD_IDX_W  = 17;

  // ALU command encodings driven by the decode stage into EX
  typedef enum logic [3:0] {
    EXE_NOP = 4'd0,
    EXE_MOV = 4'd1,
    EXE_ADD = 4'd2,
    EXE_ADC = 4'd3,
    EXE_SUB = 4'd4,
    EXE_SBC = 4'd5,
    EXE_AND = 4'd6,
    EXE_ORR = 4'd7,
    EXE_EOR = 4'd8,
    EXE_MVN = 4'd9
  } exec_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_e;

  // Request captured in IDLE and held for the whole transaction
  typedef struct packed {
    logic [WORD_IDX_W-1:0] word_idx;
    logic [DATA_W-1:0]     wdata;
    mem_op_e               op;
  } mem_req_t;

  // A simultaneous read and write request resolves to the write
  function automatic mem_op_e decode_op(input logic w_en);
    return w_en ? OP_WRITE : OP_READ;
  endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// MEM-stage request bus plus 16-bit SRAM pins seen by the access sequencer.
interface mem_access_sequencer_if;
  import mem_access_sequencer_pkg::*;

  logic                   MEM_R_EN;
  logic                   MEM_W_EN;
  logic [ADDR_W-1:0]      addr;
  logic [DATA_W-1:0]      wdata;
  logic [DATA_W-1:0]      rdata;
  logic                   ready;
  logic                   freeze;
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [HALF_W-1:0]      sram_wdata;
  logic [HALF_W-1:0]      sram_rdata;
  logic                   sram_we_n;
  logic                   sram_oe_n;

  // Pipeline + SRAM side
  modport master (
    output MEM_R_EN, MEM_W_EN, addr, wdata, sram_rdata,
    input  rdata, ready, freeze, sram_addr, sram_wdata, sram_we_n, sram_oe_n
  );

  // Sequencer side
  modport slave (
    input  MEM_R_EN, MEM_W_EN, addr, wdata, sram_rdata,
    output rdata, ready, freeze, sram_addr, sram_wdata, sram_we_n, sram_oe_n
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit SRAM accesses
// (low then high halfword), stalling the upstream pipeline until done.
module mem_access_sequencer
  import mem_access_sequencer_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  mem_access_sequencer_if.slave        bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

  seq_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  mem_req_t               req_q, req_d;
  logic [HALF_W-1:0]      lo_half_q, lo_half_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   ready_q, ready_d;
  logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [HALF_W-1:0]      sram_wdata_q, sram_wdata_d;
  logic                   we_n_q, we_n_d;
  logic                   oe_n_q, oe_n_d;

  logic req_in;
  logic cnt_last;
  logic unused_addr_bits;

  assign req_in           = bus.MEM_R_EN | bus.MEM_W_EN;
  assign cnt_last         = (cnt_q == LAST_CNT);
  assign unused_addr_bits = ^{bus.addr[ADDR_W-1:19], bus.addr[1:0]};

  // State, counter, latched request and registered SRAM/pipeline outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      lo_half_q    <= '0;
      rdata_q      <= '0;
      ready_q      <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      lo_half_q    <= lo_half_d;
      rdata_q      <= rdata_d;
      ready_q      <= ready_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      we_n_q       <= we_n_d;
      oe_n_q       <= oe_n_d;
    end
  end

  // Next state, cycle counter and request capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_in) begin
          req_d.word_idx = bus.addr[18:2];
          req_d.wdata    = bus.wdata;
          req_d.op       = decode_op(bus.MEM_W_EN);
          cnt_d          = '0;
          state_d        = ST_LOW;
        end
      end
      ST_LOW: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the upcoming state; addr/wdata hold outside LOW/HIGH
  always_comb begin
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    we_n_d       = 1'b1;
    oe_n_d       = 1'b1;
    ready_d      = (state_d == ST_DONE);
    lo_half_d    = lo_half_q;
    rdata_d      = rdata_q;

    unique case (state_d)
      ST_LOW: begin
        sram_addr_d = {req_d.word_idx, 1'b0};
        we_n_d      = (req_d.op != OP_WRITE);
        oe_n_d      = (req_d.op != OP_READ);
        if (req_d.op == OP_WRITE) sram_wdata_d = req_d.wdata[HALF_W-1:0];
      end
      ST_HIGH: begin
        sram_addr_d = {req_d.word_idx, 1'b1};
        we_n_d      = (req_d.op != OP_WRITE);
        oe_n_d      = (req_d.op != OP_READ);
        if (req_d.op == OP_WRITE) sram_wdata_d = req_d.wdata[DATA_W-1:HALF_W];
      end
      default: ;
    endcase

    // Low half is parked so rdata only changes when the whole read completes
    if (req_q.op == OP_READ && cnt_last) begin
      if (state_q == ST_LOW)  lo_half_d = bus.sram_rdata;
      if (state_q == ST_HIGH) rdata_d   = {bus.sram_rdata, lo_half_q};
    end
  end

  assign bus.freeze     = (state_q == ST_IDLE && req_in) ||
                          (state_q == ST_LOW) || (state_q == ST_HIGH);
  assign bus.rdata      = rdata_q;
  assign bus.ready      = ready_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_wdata = sram_wdata_q;
  assign bus.sram_we_n  = we_n_q;
  assign bus.sram_oe_n  = oe_n_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench: two sequencers (WAIT_CYCLES 2 and 1) on behavioural SRAMs.
module tb_mem_access_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    int          at;
    logic [31:0] data;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];

  mem_access_sequencer_if bus_a ();
  mem_access_sequencer_if bus_b ();

  mem_access_sequencer #(.WAIT_CYCLES(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  mem_access_sequencer #(.WAIT_CYCLES(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural asynchronous-read SRAMs
  assign bus_a.sram_rdata = bus_a.sram_oe_n ? 16'h0000 : mem_a[bus_a.sram_addr[7:0]];
  assign bus_b.sram_rdata = bus_b.sram_oe_n ? 16'h0000 : mem_b[bus_b.sram_addr[7:0]];
  always @(posedge clk) if (!bus_a.sram_we_n) mem_a[bus_a.sram_addr[7:0]] <= bus_a.sram_wdata;
  always @(posedge clk) if (!bus_b.sram_we_n) mem_b[bus_b.sram_addr[7:0]] <= bus_b.sram_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitors: every ready pulse must match the head of its scoreboard
  always @(negedge clk) begin
    if (bus_a.ready !== 1'b0) begin
      if (q_a.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_ready: ready=%b at cycle %0d", bus_a.ready, cyc);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        check("a_ready_cycle", cyc, e.at);
        check("a_rdata", bus_a.rdata, e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (bus_b.ready !== 1'b0) begin
      if (q_b.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_ready: ready=%b at cycle %0d", bus_b.ready, cyc);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        check("b_ready_cycle", cyc, e.at);
        check("b_rdata", bus_b.rdata, e.data);
      end
    end
  end

  // One WAIT_CYCLES=2 transaction on bus_a, starting at the current negedge
  task automatic a_xact(input string tag, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rdata, input int exp_we, input int exp_oe);
    int we_cnt;
    int oe_cnt;
    int frz_cnt;
    exp_t e;
    we_cnt = 0; oe_cnt = 0; frz_cnt = 0;
    bus_a.addr = a; bus_a.wdata = d; bus_a.MEM_R_EN = r; bus_a.MEM_W_EN = w;
    e.at = cyc + 5; e.data = exp_rdata;
    q_a.push_back(e);
    #1;
    if (bus_a.freeze) frz_cnt++;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // Garbage after acceptance must be ignored
        bus_a.MEM_R_EN = 1'b0; bus_a.MEM_W_EN = 1'b0;
        bus_a.addr = 32'hFFFF_FFFC; bus_a.wdata = 32'h0;
      end
      #1;
      if (!bus_a.sram_we_n) we_cnt++;
      if (!bus_a.sram_oe_n) oe_cnt++;
      if (bus_a.freeze) frz_cnt++;
    end
    check({tag, "_freeze_in_done"}, 32'(bus_a.freeze), 32'd0);
    check({tag, "_freeze_cycles"}, frz_cnt, 5);
    check({tag, "_we_cycles"}, we_cnt, exp_we);
    check({tag, "_oe_cycles"}, oe_cnt, exp_oe);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    bus_a.MEM_R_EN = 1'b0; bus_a.MEM_W_EN = 1'b0; bus_a.addr = '0; bus_a.wdata = '0;
    bus_b.MEM_R_EN = 1'b0; bus_b.MEM_W_EN = 1'b0; bus_b.addr = '0; bus_b.wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] <= 16'h0;
      mem_b[i] <= 16'h0;
    end
    mem_a[4] <= 16'hBEEF; mem_a[5] <= 16'hDEAD;
    mem_b[6] <= 16'h1111; mem_b[7] <= 16'h2222;

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus_a.ready), 32'd0);
    check("rst_we_n", 32'(bus_a.sram_we_n), 32'd1);
    check("rst_oe_n", 32'(bus_a.sram_oe_n), 32'd1);
    check("rst_sram_addr", 32'(bus_a.sram_addr), 32'd0);
    check("rst_sram_wdata", 32'(bus_a.sram_wdata), 32'd0);
    check("rst_rdata", bus_a.rdata, 32'd0);
    check("rst_freeze", 32'(bus_a.freeze), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Read of halfwords 4/5
    a_xact("rd", 1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'hDEAD_BEEF, 0, 4);

    // Write to halfwords 8/9; rdata must keep the last read value
    a_xact("wr", 1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'hDEAD_BEEF, 4, 0);
    check("wr_hw8", 32'(mem_a[8]), 32'h5678);
    check("wr_hw9", 32'(mem_a[9]), 32'h1234);

    // Read and write together resolve to a write
    a_xact("rw", 1'b1, 1'b1, 32'h0000_0020, 32'hAAAA_5555, 32'hDEAD_BEEF, 4, 0);
    check("rw_hw16", 32'(mem_a[16]), 32'h5555);
    check("rw_hw17", 32'(mem_a[17]), 32'hAAAA);

    // Back-to-back write then read of the same word, requests held high
    bus_a.addr = 32'h0000_0030; bus_a.wdata = 32'hCAFE_F00D; bus_a.MEM_W_EN = 1'b1;
    e.at = cyc + 5;  e.data = 32'hDEAD_BEEF; q_a.push_back(e);
    e.at = cyc + 11; e.data = 32'hCAFE_F00D; q_a.push_back(e);
    repeat (5) @(negedge clk);
    #1;
    check("b2b_freeze_done", 32'(bus_a.freeze), 32'd0);
    bus_a.MEM_W_EN = 1'b0; bus_a.MEM_R_EN = 1'b1;
    @(negedge clk);
    #1;
    check("b2b_freeze_accept", 32'(bus_a.freeze), 32'd1);
    repeat (5) @(negedge clk);
    bus_a.MEM_R_EN = 1'b0;
    @(negedge clk);
    check("b2b_hw24", 32'(mem_a[24]), 32'hF00D);
    check("b2b_hw25", 32'(mem_a[25]), 32'hCAFE);

    // Reset during the HIGH phase of a read
    bus_a.addr = 32'h0000_0008; bus_a.MEM_R_EN = 1'b1;
    @(negedge clk);
    bus_a.MEM_R_EN = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_oe_before_rst", 32'(bus_a.sram_oe_n), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_oe_n", 32'(bus_a.sram_oe_n), 32'd1);
    check("mid_rst_we_n", 32'(bus_a.sram_we_n), 32'd1);
    check("mid_rst_rdata", bus_a.rdata, 32'd0);
    check("mid_rst_ready", 32'(bus_a.ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("mid_rst_rdata_after", bus_a.rdata, 32'd0);
    check("mid_rst_freeze_after", 32'(bus_a.freeze), 32'd0);

    // WAIT_CYCLES=1 instance: ready three cycles after the request
    bus_b.addr = 32'h0000_000C; bus_b.MEM_R_EN = 1'b1;
    e.at = cyc + 3; e.data = 32'h2222_1111; q_b.push_back(e);
    @(negedge clk);
    bus_b.MEM_R_EN = 1'b0;
    repeat (5) @(negedge clk);

    check("a_scoreboard_empty", 32'(q_a.size()), 32'd0);
    check("b_scoreboard_empty", 32'(q_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
